// File: rtl/sys_mem_pkg.sv
// Shared widths and requester IDs for the on-chip RAM arbiter slice.
package sys_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

endpackage

// File: rtl/sys_rr_arb2.sv
// Two-way combinational grant with a last-grant flop; round-robin or m0-fixed priority.
// Grants are forced low while reset_n is asserted.
module sys_rr_arb2
  import sys_mem_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  port_e r_last_gnt;
  logic  w_m0_wins_tie;

  // Reset leaves m1 as last owner so m0 takes the first tie.
  assign w_m0_wins_tie = FIXED_PRI | (r_last_gnt == PORT_M1);

  assign o_gnt0 = reset_n & i_req0 & (~i_req1 | w_m0_wins_tie);
  assign o_gnt1 = reset_n & i_req1 & ~o_gnt0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= PORT_M1;
    end else if (o_gnt0) begin
      r_last_gnt <= PORT_M0;
    end else if (o_gnt1) begin
      r_last_gnt <= PORT_M1;
    end
  end

endmodule

// File: rtl/sys_onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters, one access per clk.
// Reads return exactly 1 clk after acceptance; losers see waitrequest and must hold.
module sys_onchip_mem_arbiter
  import sys_mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BE_W      = MEM_BE_W,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic  w_m0_req;
  logic  w_m1_req;
  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_rd_issue;
  logic  r_rd_vld;
  port_e r_rd_id;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

  sys_rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req0  (w_m0_req),
    .i_req1  (w_m1_req),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  assign m0_waitrequest = w_m0_req & ~w_gnt0;
  assign m1_waitrequest = w_m1_req & ~w_gnt1;

  // A port raising read and write together is served as a write.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    w_rd_issue     = 1'b0;
    if (w_gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      ram_write      = m0_write;
      w_rd_issue     = m0_read & ~m0_write;
    end else if (w_gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
      w_rd_issue     = m1_read & ~m1_write;
    end
  end

  assign ram_chipselect = w_gnt0 | w_gnt1;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= 1'b0;
      r_rd_id  <= PORT_M0;
    end else begin
      r_rd_vld <= w_rd_issue;
      r_rd_id  <= w_gnt1 ? PORT_M1 : PORT_M0;
    end
  end

  assign m0_readdatavalid = r_rd_vld & (r_rd_id == PORT_M0);
  assign m1_readdatavalid = r_rd_vld & (r_rd_id == PORT_M1);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule
